// File: rtl/store_buffer.sv
// Posted-write store queue with youngest-match load forwarding between the CPU memory stage and data memory.
// Latency: a store is written to memory no earlier than the cycle after it is accepted; loads and forwarding are combinational.
// Backpressure: stall is raised when the queue is full with no drain that cycle, and while a flush is emptying the queue.
//
// Ports:
//   clk, rst                         clock, synchronous active-low reset
//   cpuAdr, cpuWriteData             CPU byte address and store data
//   cpuMemRead, cpuMemWrite, flush   load / store / drain request from the CPU
//   cpuReadData, stall               load result (forwarded or from memory), pipeline freeze
//   memAdr, memWriteData, memRead,   data memory port; memWrite pops the head entry
//   memWrite, memReadData, memBusy
//   count                            number of queued stores
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADR_W  = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADR_W-1:0]         cpuAdr,
    input  logic [DATA_W-1:0]        cpuWriteData,
    input  logic                     cpuMemRead,
    input  logic                     cpuMemWrite,
    input  logic                     flush,
    output logic [DATA_W-1:0]        cpuReadData,
    output logic                     stall,
    output logic [ADR_W-1:0]         memAdr,
    output logic [DATA_W-1:0]        memWriteData,
    output logic                     memRead,
    output logic                     memWrite,
    input  logic [DATA_W-1:0]        memReadData,
    input  logic                     memBusy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } entryT;

    typedef enum logic {
        RUN,
        FLUSHING
    } stateT;

    entryT              entries [DEPTH];
    logic [DEPTH-1:0]   entryValid;
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    stateT              state;
    stateT              stateNext;

    logic [ADR_W-1:0]   alignedAdr;
    logic               notEmpty;
    logic               full;
    logic               flushActive;
    logic               drain;
    logic               accept;
    logic               fwdHit;
    logic [DATA_W-1:0]  fwdData;

    // Clearing the low bits with a mask keeps every address bit in use.
    assign alignedAdr = cpuAdr & ~ADR_W'(3);
    assign notEmpty   = (count != '0);
    assign full       = (count == FULL_COUNT);

    // ---------------------------------------------------------------
    // Control FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // ---------------------------------------------------------------
    // Control FSM: next state and handshake outputs
    // ---------------------------------------------------------------
    always_comb begin
        stateNext   = state;
        flushActive = 1'b0;
        drain       = 1'b0;
        stall       = 1'b0;
        accept      = 1'b0;

        case (state)
            RUN: begin
                // A flush raised in RUN already freezes the CPU in the
                // same cycle, so an N-entry queue costs exactly N stalls.
                flushActive = flush;
                if (flush) begin
                    stateNext = FLUSHING;
                end
            end
            FLUSHING: begin
                flushActive = 1'b1;
                if (!notEmpty) begin
                    stateNext = RUN;
                end
            end
            default: begin
                stateNext = RUN;
            end
        endcase

        // A load owns the memory port, so it blocks the drain. The CPU
        // is expected not to present a load while a flush is pending.
        // Everything is gated by rst so nothing reaches memory or the
        // CPU during the reset cycle.
        drain  = rst & notEmpty & ~memBusy & ~cpuMemRead;
        stall  = rst & ((flushActive & notEmpty) | (cpuMemWrite & full & ~drain));
        accept = rst & cpuMemWrite & ~stall;
    end

    // ---------------------------------------------------------------
    // Pointers, occupancy and valid bits
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            entryValid <= '0;
        end else begin
            if (drain) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (accept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            case ({accept, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // When full, accept and drain hit the same slot; the set must win.
            for (int i = 0; i < DEPTH; i++) begin
                if (drain && (rdPtr == PTR_W'(i))) begin
                    entryValid[i] <= 1'b0;
                end
                if (accept && (wrPtr == PTR_W'(i))) begin
                    entryValid[i] <= 1'b1;
                end
            end
        end
    end

    // Entry payload needs no reset: valid bits qualify every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            entries[wrPtr] <= '{adr: alignedAdr, data: cpuWriteData};
        end
    end

    // ---------------------------------------------------------------
    // Load forwarding: scan oldest to youngest so the youngest hit wins
    // ---------------------------------------------------------------
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            idx = rdPtr + PTR_W'(i);
            if (entryValid[idx] && (entries[idx].adr == alignedAdr)) begin
                fwdHit  = 1'b1;
                fwdData = entries[idx].data;
            end
        end
    end

    // ---------------------------------------------------------------
    // Output muxing
    // ---------------------------------------------------------------
    assign memRead      = cpuMemRead;
    assign memWrite     = drain;
    assign memAdr       = drain ? entries[rdPtr].adr : alignedAdr;
    assign memWriteData = entries[rdPtr].data;
    assign cpuReadData  = !cpuMemRead ? '0 : (fwdHit ? fwdData : memReadData);

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk;
    logic        rst;
    logic [31:0] cpuAdr;
    logic [31:0] cpuWriteData;
    logic        cpuMemRead;
    logic        cpuMemWrite;
    logic        flush;
    logic [31:0] cpuReadData;
    logic        stall;
    logic [31:0] memAdr;
    logic [31:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memReadData;
    logic        memBusy;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(4), .ADR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cpuAdr       (cpuAdr),
        .cpuWriteData (cpuWriteData),
        .cpuMemRead   (cpuMemRead),
        .cpuMemWrite  (cpuMemWrite),
        .flush        (flush),
        .cpuReadData  (cpuReadData),
        .stall        (stall),
        .memAdr       (memAdr),
        .memWriteData (memWriteData),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memReadData  (memReadData),
        .memBusy      (memBusy),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: 256 words, preset to a recognisable pattern on memInit.
    logic [31:0] mem [0:255];
    logic        memInit;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 | i;
    endfunction

    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(i);
        end else if (memWrite) begin
            mem[memAdr[9:2]] <= memWriteData;
        end
    end
    assign memReadData = mem[memAdr[9:2]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Directed vectors: inputs for one cycle plus the outputs expected
    // before the following rising edge. cnt < 0 means count unchecked.
    typedef struct {
        logic        rst, rd, wr, fl, bz;
        logic [31:0] adr, wd;
        logic        st, mw;
        logic [31:0] madr, mwd, rdd;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic r, input logic rd, input logic wr, input logic fl, input logic bz,
                       input logic [31:0] adr, input logic [31:0] wd,
                       input logic st, input logic mw,
                       input logic [31:0] madr, input logic [31:0] mwd, input logic [31:0] rdd,
                       input int cnt);
        vec_t v;
        v.rst = r; v.rd = rd; v.wr = wr; v.fl = fl; v.bz = bz;
        v.adr = adr; v.wd = wd; v.st = st; v.mw = mw;
        v.madr = madr; v.mwd = mwd; v.rdd = rdd; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    // Reference model state for the randomized phase.
    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] refMem [0:255];
    bit          mFlush;

    initial begin
        // reset and single store drained the next cycle
        row(0,0,0,0,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, -1);
        row(1,0,1,0,0, 32'h3E8,  32'h1234,   0,0, 32'h3E8, 32'h0,    32'h0, 0);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,1, 32'h3E8, 32'h1234, 32'h0, 1);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, 0);
        // fill while busy, full stall, then full+drain accepts
        row(1,0,1,0,1, 32'h0,    32'h10,     0,0, 32'h0,   32'h0,    32'h0, 0);
        row(1,0,1,0,1, 32'h4,    32'h11,     0,0, 32'h4,   32'h0,    32'h0, 1);
        row(1,0,1,0,1, 32'h8,    32'h12,     0,0, 32'h8,   32'h0,    32'h0, 2);
        row(1,0,1,0,1, 32'hC,    32'h13,     0,0, 32'hC,   32'h0,    32'h0, 3);
        row(1,0,1,0,1, 32'h10,   32'h14,     1,0, 32'h10,  32'h0,    32'h0, 4);
        row(1,0,1,0,1, 32'h10,   32'h14,     1,0, 32'h10,  32'h0,    32'h0, 4);
        row(1,0,1,0,0, 32'h10,   32'h14,     0,1, 32'h0,   32'h10,   32'h0, 4);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,1, 32'h4,   32'h11,   32'h0, 4);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,1, 32'h8,   32'h12,   32'h0, 3);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,1, 32'hC,   32'h13,   32'h0, 2);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,1, 32'h10,  32'h14,   32'h0, 1);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, 0);
        // forwarding: youngest of two matches, miss, drained data in memory
        row(1,0,1,0,1, 32'h100,  32'hAAAA,   0,0, 32'h100, 32'h0,    32'h0, 0);
        row(1,0,1,0,1, 32'h100,  32'hBBBB,   0,0, 32'h100, 32'h0,    32'h0, 1);
        row(1,1,0,0,1, 32'h102,  32'h0,      0,0, 32'h100, 32'h0,    32'hBBBB, 2);
        row(1,1,0,0,0, 32'h200,  32'h0,      0,0, 32'h200, 32'h0,    32'hC0DE0080, 2);
        row(1,1,0,0,0, 32'h3E8,  32'h0,      0,0, 32'h3E8, 32'h0,    32'h1234, 2);
        row(1,1,0,0,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h10, 2);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,1, 32'h100, 32'hAAAA, 32'h0, 2);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,1, 32'h100, 32'hBBBB, 32'h0, 1);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, 0);
        // flush of three entries, then flush on an empty queue
        row(1,0,1,0,1, 32'h20,   32'h1,      0,0, 32'h20,  32'h0,    32'h0, 0);
        row(1,0,1,0,1, 32'h24,   32'h2,      0,0, 32'h24,  32'h0,    32'h0, 1);
        row(1,0,1,0,1, 32'h28,   32'h3,      0,0, 32'h28,  32'h0,    32'h0, 2);
        row(1,0,0,1,0, 32'h0,    32'h0,      1,1, 32'h20,  32'h1,    32'h0, 3);
        row(1,0,0,1,0, 32'h0,    32'h0,      1,1, 32'h24,  32'h2,    32'h0, 2);
        row(1,0,0,1,0, 32'h0,    32'h0,      1,1, 32'h28,  32'h3,    32'h0, 1);
        row(1,0,0,1,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, 0);
        row(1,0,0,1,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, 0);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, 0);
        // reset with two queued entries discards them
        row(1,0,1,0,1, 32'h30,   32'h77,     0,0, 32'h30,  32'h0,    32'h0, 0);
        row(1,0,1,0,1, 32'h34,   32'h78,     0,0, 32'h34,  32'h0,    32'h0, 1);
        row(0,0,0,0,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, 2);
        row(1,0,0,0,0, 32'h0,    32'h0,      0,0, 32'h0,   32'h0,    32'h0, 0);
        row(1,1,0,0,0, 32'h30,   32'h0,      0,0, 32'h30,  32'h0,    32'hC0DE000C, 0);
        row(1,1,0,0,0, 32'h34,   32'h0,      0,0, 32'h34,  32'h0,    32'hC0DE000D, 0);

        rst = 1'b0; cpuAdr = '0; cpuWriteData = '0; cpuMemRead = 1'b0;
        cpuMemWrite = 1'b0; flush = 1'b0; memBusy = 1'b0; memInit = 1'b1;
        @(negedge clk);
        memInit = 1'b0;

        foreach (vecs[k]) begin
            rst = vecs[k].rst; cpuMemRead = vecs[k].rd; cpuMemWrite = vecs[k].wr;
            flush = vecs[k].fl; memBusy = vecs[k].bz;
            cpuAdr = vecs[k].adr; cpuWriteData = vecs[k].wd;
            #2;
            chk($sformatf("v%0d stall", k), 32'(stall), 32'(vecs[k].st));
            chk($sformatf("v%0d memWrite", k), 32'(memWrite), 32'(vecs[k].mw));
            chk($sformatf("v%0d memAdr", k), memAdr, vecs[k].madr);
            chk($sformatf("v%0d memRead", k), 32'(memRead), 32'(vecs[k].rd));
            chk($sformatf("v%0d cpuReadData", k), cpuReadData, vecs[k].rdd);
            if (vecs[k].mw) chk($sformatf("v%0d memWriteData", k), memWriteData, vecs[k].mwd);
            if (vecs[k].cnt >= 0) chk($sformatf("v%0d count", k), 32'(count), vecs[k].cnt);
            @(negedge clk);
        end

        // Randomized phase against the queue model; start from a clean reset.
        rst = 1'b0; memInit = 1'b1; cpuMemRead = 1'b0; cpuMemWrite = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst = 1'b1; memInit = 1'b0;
        for (int i = 0; i < 256; i++) refMem[i] = pat(i);
        q.delete();
        mFlush = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            int op;
            int qn;
            bit fl, eDrain, eStall;
            logic [31:0] a, al, eRd, eAdr;
            op = $urandom_range(0, 9);
            a  = $urandom_range(0, 63);
            al = a & 32'hFFFF_FFFC;
            cpuAdr       = a;
            cpuWriteData = $urandom;
            cpuMemWrite  = (op <= 3);
            cpuMemRead   = (op >= 4 && op <= 6);
            memBusy      = ($urandom_range(0, 2) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            #2;
            qn     = q.size();
            fl     = mFlush || flush;
            eDrain = (qn > 0) && !memBusy && !cpuMemRead;
            eStall = (fl && qn > 0) || (cpuMemWrite && qn == 4 && !eDrain);
            eRd    = 32'h0;
            if (cpuMemRead) begin
                eRd = refMem[al[9:2]];
                foreach (q[k]) if (q[k].adr == al) eRd = q[k].data;
            end
            eAdr = eDrain ? q[0].adr : al;
            chk("rnd count", 32'(count), qn);
            chk("rnd stall", 32'(stall), 32'(eStall));
            chk("rnd memWrite", 32'(memWrite), 32'(eDrain));
            chk("rnd memAdr", memAdr, eAdr);
            chk("rnd cpuReadData", cpuReadData, eRd);
            if (eDrain) chk("rnd memWriteData", memWriteData, q[0].data);
            if (eDrain) begin
                refMem[q[0].adr[9:2]] = q[0].data;
                void'(q.pop_front());
            end
            if (cpuMemWrite && !eStall) q.push_back('{adr: al, data: cpuWriteData});
            mFlush = mFlush ? (qn != 0) : flush;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
